lsu_mem_stage: RTL and testbench

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_mem_stage.sv | 156 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: registers ALU results and runs single-outstanding dmem transactions.
// Optional build macro MISALIGN_TRAP_EN turns misaligned accesses into flagged no-ops instead of aligning them.
module lsu_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        wreg_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] store_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    output logic [7:0]  dmem_wmask_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        valid_o,
    output logic [4:0]  rd_addr_o,
    output logic        wreg_o,
    output logic [63:0] wdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [4:0]  mem_back_rd_addr_o,
    output logic        mem_back_wreg_o,
    output logic [63:0] mem_back_wdata_o
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, state_nxt;

    logic        is_load, is_store, is_ls, nop_f3, trap, mem_op, start;
    logic [2:0]  amask, off;
    logic [63:0] eff_addr, st_data, shifted, load_data;
    logic [7:0]  st_mask;
    logic [2:0]  req_funct3, req_off;
    logic [4:0]  req_rd;
    logic        req_wreg;

    always_comb begin
        is_load  = (opcode_i == OP_LOAD);
        is_store = (opcode_i == OP_STORE);
        is_ls    = is_load | is_store;
        nop_f3   = (funct3_i == 3'b111);
        case (funct3_i[1:0])
            2'b00:   amask = 3'b000;
            2'b01:   amask = 3'b001;
            2'b10:   amask = 3'b011;
            default: amask = 3'b111;
        endcase
`ifdef MISALIGN_TRAP_EN
        trap     = is_ls & ~nop_f3 & (|(wdata_i[2:0] & amask));
        eff_addr = wdata_i;
`else
        trap     = 1'b0;
        eff_addr = {wdata_i[63:3], wdata_i[2:0] & ~amask};
`endif
        mem_op   = is_ls & ~nop_f3 & ~trap;
        start    = (state == S_IDLE) & valid_i & mem_op;
        off      = eff_addr[2:0];
        case (funct3_i[1:0])
            2'b00:   st_mask = 8'h01 << off;
            2'b01:   st_mask = 8'h03 << off;
            2'b10:   st_mask = 8'h0F << off;
            default: st_mask = 8'hFF;
        endcase
        st_data  = store_data_i << {off, 3'b000};
    end

    always_comb begin
        shifted = dmem_rdata_i >> {req_off, 3'b000};
        case (req_funct3)
            3'b000:  load_data = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  load_data = {56'd0, shifted[7:0]};
            3'b101:  load_data = {48'd0, shifted[15:0]};
            3'b110:  load_data = {32'd0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_WAIT;
            S_WAIT: if (dmem_ack_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o = (state == S_WAIT);
        stall_o    = start | ((state == S_WAIT) & ~dmem_ack_i);
    end

    // Request fields are captured once on entry so they stay stable for the whole wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_wmask_o <= '0;
            req_funct3   <= '0;
            req_off      <= '0;
            req_rd       <= '0;
            req_wreg     <= 1'b0;
            valid_o      <= 1'b0;
            rd_addr_o    <= '0;
            wreg_o       <= 1'b0;
            wdata_o      <= '0;
            misalign_o   <= 1'b0;
        end else begin
            if (start) begin
                dmem_we_o    <= is_store;
                dmem_addr_o  <= {eff_addr[63:3], 3'b000};
                dmem_wdata_o <= is_store ? st_data : 64'd0;
                dmem_wmask_o <= is_store ? st_mask : 8'd0;
                req_funct3   <= funct3_i;
                req_off      <= off;
                req_rd       <= rd_addr_i;
                req_wreg     <= is_load & wreg_i & (rd_addr_i != 5'd0);
            end
            if ((state == S_WAIT) && dmem_ack_i) begin
                valid_o    <= 1'b1;
                rd_addr_o  <= req_rd;
                wreg_o     <= req_wreg;
                wdata_o    <= load_data;
                misalign_o <= 1'b0;
            end else if ((state == S_IDLE) && valid_i && !mem_op) begin
                valid_o    <= 1'b1;
                rd_addr_o  <= rd_addr_i;
                wreg_o     <= wreg_i & (rd_addr_i != 5'd0) & ~is_ls;
                wdata_o    <= wdata_i;
                misalign_o <= trap;
            end else begin
                valid_o    <= 1'b0;
                wreg_o     <= 1'b0;
                misalign_o <= 1'b0;
            end
        end
    end

    assign mem_back_rd_addr_o = rd_addr_o;
    assign mem_back_wreg_o    = wreg_o & valid_o;
    assign mem_back_wdata_o   = wdata_o;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: pass-through, loads, stores, misalignment and reset-in-wait.
module tb_lsu_mem_stage;
    logic        clk, rst, valid_i, wreg_i, dmem_ack_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_addr_i;
    logic [63:0] wdata_i, store_data_i, dmem_rdata_i;
    logic        dmem_req_o, dmem_we_o, valid_o, wreg_o, stall_o, misalign_o, mem_back_wreg_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o, wdata_o, mem_back_wdata_o;
    logic [7:0]  dmem_wmask_o;
    logic [4:0]  rd_addr_o, mem_back_rd_addr_o;

    int checks = 0;
    int failures = 0;
    int stalls;
    logic [63:0] cap_addr, cap_wdata;
    logic [7:0]  cap_wmask;
    logic        cap_we, cap_req;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    lsu_mem_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .rd_addr_i(rd_addr_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .store_data_i(store_data_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o), .rd_addr_o(rd_addr_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stall_o(stall_o), .misalign_o(misalign_o),
        .mem_back_rd_addr_o(mem_back_rd_addr_o), .mem_back_wreg_o(mem_back_wreg_o),
        .mem_back_wdata_o(mem_back_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic wr, input logic [63:0] wd, input logic [63:0] sd);
        valid_i = 1'b1; opcode_i = op; funct3_i = f3; rd_addr_i = rd;
        wreg_i = wr; wdata_i = wd; store_data_i = sd;
    endtask

    // Entered at a falling edge with a memory op already driven; leaves 1ns after the completing edge.
    task automatic do_mem(input int lat, input logic [63:0] rdata, output int nstall);
        nstall = 0;
        #1;
        if (stall_o) nstall++;
        @(posedge clk); #1;
        for (int i = 0; i < lat; i++) begin
            check("wait_req", {63'd0, dmem_req_o}, 64'd1);
            check("wait_valid", {63'd0, valid_o}, 64'd0);
            if (stall_o) nstall++;
            @(posedge clk); #1;
        end
        cap_addr = dmem_addr_o; cap_wdata = dmem_wdata_o; cap_wmask = dmem_wmask_o;
        cap_we = dmem_we_o; cap_req = dmem_req_o;
        dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
        #1;
        if (stall_o) nstall++;
        @(posedge clk); #1;
        dmem_ack_i = 1'b0; valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; opcode_i = '0; funct3_i = '0; rd_addr_i = '0; wreg_i = 1'b0;
        wdata_i = '0; store_data_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_wreg", {63'd0, wreg_o}, 64'd0);
        check("rst_req", {63'd0, dmem_req_o}, 64'd0);
        check("rst_we", {63'd0, dmem_we_o}, 64'd0);
        check("rst_addr", dmem_addr_o, 64'd0);
        check("rst_wdata", wdata_o, 64'd0);
        check("rst_mask", {56'd0, dmem_wmask_o}, 64'd0);
        check("rst_mis", {63'd0, misalign_o}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // ADD pass-through
        drive(OP_ALU, 3'b000, 5'd3, 1'b1, 64'h5, 64'h0);
        #1; check("add_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        check("add_valid", {63'd0, valid_o}, 64'd1);
        check("add_wreg", {63'd0, wreg_o}, 64'd1);
        check("add_wdata", wdata_o, 64'h5);
        check("add_rd", {59'd0, rd_addr_o}, 64'd3);
        check("add_fwd_wreg", {63'd0, mem_back_wreg_o}, 64'd1);
        check("add_fwd_rd", {59'd0, mem_back_rd_addr_o}, 64'd3);
        check("add_fwd_data", mem_back_wdata_o, 64'h5);
        check("add_req", {63'd0, dmem_req_o}, 64'd0);
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("idle_valid", {63'd0, valid_o}, 64'd0);
        check("idle_fwd_wreg", {63'd0, mem_back_wreg_o}, 64'd0);

        // rd = 0 suppresses write
        @(negedge clk); drive(OP_ALU, 3'b000, 5'd0, 1'b1, 64'h77, 64'h0);
        @(posedge clk); #1;
        check("rd0_valid", {63'd0, valid_o}, 64'd1);
        check("rd0_wreg", {63'd0, wreg_o}, 64'd0);
        valid_i = 1'b0;

        // LB 0x1003, three wait cycles before ack
        @(negedge clk); drive(OP_LOAD, 3'b000, 5'd5, 1'b1, 64'h1003, 64'h0);
        do_mem(3, 64'h00000000_80000000, stalls);
        check("lb_stalls", 64'(stalls), 64'd4);
        check("lb_addr", cap_addr, 64'h1000);
        check("lb_we", {63'd0, cap_we}, 64'd0);
        check("lb_valid", {63'd0, valid_o}, 64'd1);
        check("lb_wreg", {63'd0, wreg_o}, 64'd1);
        check("lb_rd", {59'd0, rd_addr_o}, 64'd5);
        check("lb_data", wdata_o, 64'hFFFFFFFF_FFFFFF80);
        check("lb_req_drop", {63'd0, dmem_req_o}, 64'd0);

        // LWU 0x2004
        @(negedge clk); drive(OP_LOAD, 3'b110, 5'd6, 1'b1, 64'h2004, 64'h0);
        do_mem(0, 64'h87654321_00000000, stalls);
        check("lwu_stalls", 64'(stalls), 64'd1);
        check("lwu_addr", cap_addr, 64'h2000);
        check("lwu_data", wdata_o, 64'h00000000_87654321);

        // LHU 0x6006
        @(negedge clk); drive(OP_LOAD, 3'b101, 5'd8, 1'b1, 64'h6006, 64'h0);
        do_mem(1, 64'h8001_0000_0000_0000, stalls);
        check("lhu_data", wdata_o, 64'h8001);

        // LD 0x8000
        @(negedge clk); drive(OP_LOAD, 3'b011, 5'd9, 1'b1, 64'h8000, 64'h0);
        do_mem(0, 64'hDEADBEEF_CAFEF00D, stalls);
        check("ld_data", wdata_o, 64'hDEADBEEF_CAFEF00D);

        // SH 0x3002
        @(negedge clk); drive(OP_STORE, 3'b001, 5'd7, 1'b1, 64'h3002, 64'hBEEF);
        do_mem(1, 64'h0, stalls);
        check("sh_stalls", 64'(stalls), 64'd2);
        check("sh_req", {63'd0, cap_req}, 64'd1);
        check("sh_we", {63'd0, cap_we}, 64'd1);
        check("sh_addr", cap_addr, 64'h3000);
        check("sh_mask", {56'd0, cap_wmask}, 64'h0C);
        check("sh_wdata", cap_wdata, 64'h00000000_BEEF0000);
        check("sh_valid", {63'd0, valid_o}, 64'd1);
        check("sh_wreg", {63'd0, wreg_o}, 64'd0);

        // SB 0x7005
        @(negedge clk); drive(OP_STORE, 3'b000, 5'd0, 1'b0, 64'h7005, 64'hAB);
        do_mem(0, 64'h0, stalls);
        check("sb_mask", {56'd0, cap_wmask}, 64'h20);
        check("sb_wdata", cap_wdata, 64'h0000AB00_00000000);

        // LW 0x4002 misaligned
        @(negedge clk); drive(OP_LOAD, 3'b010, 5'd10, 1'b1, 64'h4002, 64'h0);
`ifdef MISALIGN_TRAP_EN
        #1; check("mis_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        check("mis_valid", {63'd0, valid_o}, 64'd1);
        check("mis_wreg", {63'd0, wreg_o}, 64'd0);
        check("mis_flag", {63'd0, misalign_o}, 64'd1);
        check("mis_req", {63'd0, dmem_req_o}, 64'd0);
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("mis_flag_clr", {63'd0, misalign_o}, 64'd0);
`else
        do_mem(0, 64'h11223344_AABBCCDD, stalls);
        check("lw_al_addr", cap_addr, 64'h4000);
        check("lw_al_data", wdata_o, 64'hFFFFFFFF_AABBCCDD);
        check("lw_al_mis", {63'd0, misalign_o}, 64'd0);
`endif

        // funct3 111 load: no-op
        @(negedge clk); drive(OP_LOAD, 3'b111, 5'd4, 1'b1, 64'h9000, 64'h0);
        #1; check("nop_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        check("nop_valid", {63'd0, valid_o}, 64'd1);
        check("nop_wreg", {63'd0, wreg_o}, 64'd0);
        check("nop_req", {63'd0, dmem_req_o}, 64'd0);
        valid_i = 1'b0;

        // reset while waiting, late ack ignored
        @(negedge clk); drive(OP_LOAD, 3'b011, 5'd11, 1'b1, 64'h5000, 64'h0);
        @(posedge clk); #1;
        check("rw_req", {63'd0, dmem_req_o}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0;
        check("rw_req_drop", {63'd0, dmem_req_o}, 64'd0);
        check("rw_valid", {63'd0, valid_o}, 64'd0);
        @(negedge clk); dmem_ack_i = 1'b1; dmem_rdata_i = 64'h1234;
        #1; check("rw_ack_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        check("rw_late_valid", {63'd0, valid_o}, 64'd0);
        check("rw_late_req", {63'd0, dmem_req_o}, 64'd0);
        dmem_ack_i = 1'b0;
        @(posedge clk); #1;
        check("rw_after_valid", {63'd0, valid_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
